// File: rtl/ly_2257_5.sv
`default_nettype none
// ============================================================================
// Module   : ly_2257_5
// Purpose  : Push-button counter with a seven-segment output. The active-low
//            key is passed through a two-flop synchroniser and then debounced.
//            Each debounced press advances a modulo-10 count, which is decoded
//            for a common-cathode digit. A carry flag is raised while the
//            count is 9.
// Ports    : clk       - system clock, rising edge (50 MHz nominal)
//            reset_n   - asynchronous reset, active HIGH despite the name
//            key       - raw push-button, 0 = pressed
//            key_state - debounced key level, 0 = pressed
//            Q         - count 0..9
//            codeout   - segments {g,f,e,d,c,b,a}, active high
//            CO        - high while Q == 9
// Revision : 1.0 - initial release
// ============================================================================
module ly_2257_5 #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key,
    output logic       key_state,
    output logic [3:0] Q,
    output logic [6:0] codeout,
    output logic       CO
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       c_q_last  = 4'd9;

    logic [1:0]       r_sync_q;
    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_key_state_q;
    logic             w_key_state_d;
    logic [3:0]       r_q_q;
    logic [3:0]       w_q_d;
    logic             w_key_sync;
    logic             w_press;

    assign w_key_sync = r_sync_q[1];

    // Debounce: the counter only runs while the synchronised key disagrees
    // with the debounced level; any agreement restarts the window.
    always_comb begin
        w_cnt_d       = '0;
        w_key_state_d = r_key_state_q;
        w_press       = 1'b0;
        if (w_key_sync != r_key_state_q) begin
            if (r_cnt_q == c_cnt_max) begin
                w_key_state_d = w_key_sync;
                w_cnt_d       = '0;
                // Only the 1->0 transition of the debounced level counts.
                w_press       = ~w_key_sync;
            end else begin
                w_cnt_d = r_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_q_d = r_q_q;
        if (w_press) begin
            w_q_d = (r_q_q == c_q_last) ? 4'd0 : r_q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_sync_q      <= 2'b11;
            r_cnt_q       <= '0;
            r_key_state_q <= 1'b1;
            r_q_q         <= 4'd0;
        end else begin
            r_sync_q      <= {r_sync_q[0], key};
            r_cnt_q       <= w_cnt_d;
            r_key_state_q <= w_key_state_d;
            r_q_q         <= w_q_d;
        end
    end

    always_comb begin
        case (r_q_q)
            4'd0:    codeout = 7'h3F;
            4'd1:    codeout = 7'h06;
            4'd2:    codeout = 7'h5B;
            4'd3:    codeout = 7'h4F;
            4'd4:    codeout = 7'h66;
            4'd5:    codeout = 7'h6D;
            4'd6:    codeout = 7'h7D;
            4'd7:    codeout = 7'h07;
            4'd8:    codeout = 7'h7F;
            4'd9:    codeout = 7'h6F;
            default: codeout = 7'h00;
        endcase
    end

    assign key_state = r_key_state_q;
    assign Q         = r_q_q;
    assign CO        = (r_q_q == c_q_last);

endmodule
`default_nettype wire

// File: tb/tb_ly_2257_5.sv
`default_nettype none
// ============================================================================
// Module   : tb_ly_2257_5
// Purpose  : Scoreboard bench for ly_2257_5 with a short debounce window.
//            Stimulus pushes the expected display state for every press that
//            should count; a monitor pops and compares whenever Q changes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ly_2257_5;

    localparam int DEB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b1;
    logic       key_state;
    logic [3:0] q;
    logic [6:0] codeout;
    logic       co;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] q;
        logic [6:0] seg;
        logic       co;
    } exp_t;

    exp_t sb[$];

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    ly_2257_5 #(.DEBOUNCE_CYCLES(DEB), .CNT_W(5)) dut (
        .clk       (clk),
        .reset_n   (rst),
        .key       (key),
        .key_state (key_state),
        .Q         (q),
        .codeout   (codeout),
        .CO        (co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_digit(input int d);
        exp_t e;
        e.q   = 4'(d);
        e.seg = seg_tab[d];
        e.co  = (d == 9);
        sb.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every change of Q must match the oldest pending expectation.
    logic [3:0] prev_q = 4'd0;
    always @(negedge clk) begin
        if (rst) begin
            prev_q = 4'd0;
        end else if (q !== prev_q) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_q_change: got %0d, expected %0d", q, prev_q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q", int'(q), int'(e.q));
                chk("codeout", int'(codeout), int'(e.seg));
                chk("co", int'(co), int'(e.co));
            end
            prev_q = q;
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            cycles(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got %0d pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic press(input int d);
        expect_digit(d);
        key = 1'b0;
        cycles(40);
        chk("key_state_pressed", int'(key_state), 0);
        key = 1'b1;
        cycles(40);
        chk("key_state_released", int'(key_state), 1);
        drain("press");
    endtask

    initial begin
        cycles(10);
        chk("rst_key_state", int'(key_state), 1);
        chk("rst_q", int'(q), 0);
        chk("rst_codeout", int'(codeout), 'h3F);
        chk("rst_co", int'(co), 0);
        @(negedge clk);
        rst = 1'b0;
        cycles(40);
        chk("idle_q", int'(q), 0);
        chk("idle_key_state", int'(key_state), 1);

        // Ten clean presses: 1..9 then wrap to 0.
        for (int i = 1; i <= 10; i++) press(i % 10);
        chk("wrap_co", int'(co), 0);

        // Bouncing edge shorter than the window, then a stable press.
        for (int i = 0; i < 6; i++) begin
            key = ~key;
            cycles(5);
            chk("bounce_key_state", int'(key_state), 1);
        end
        press(1);

        // Glitch of DEB-1 clocks must be rejected.
        key = 1'b0;
        cycles(DEB - 1);
        key = 1'b1;
        cycles(40);
        chk("glitch_key_state", int'(key_state), 1);
        chk("glitch_q", int'(q), 1);

        // Exactly DEB clocks low is the shortest accepted press.
        expect_digit(2);
        key = 1'b0;
        cycles(DEB);
        key = 1'b1;
        cycles(40);
        drain("min_press");
        chk("min_press_q", int'(q), 2);

        for (int d = 3; d <= 7; d++) press(d);
        chk("pre_reset_q", int'(q), 7);

        // Asynchronous reset in the middle of a debounce window.
        key = 1'b0;
        cycles(10);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_q", int'(q), 0);
        chk("async_rst_key_state", int'(key_state), 1);
        chk("async_rst_co", int'(co), 0);
        chk("async_rst_codeout", int'(codeout), 'h3F);
        cycles(3);
        @(negedge clk);
        rst = 1'b0;
        expect_digit(1);
        cycles(DEB - 2);
        chk("post_rst_window_key_state", int'(key_state), 1);
        chk("post_rst_window_q", int'(q), 0);
        drain("post_rst");
        chk("post_rst_key_state", int'(key_state), 0);
        key = 1'b1;
        cycles(40);
        chk("final_q", int'(q), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
